mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one external memory port between the CPU instruction bus (ibus) and data bus (dbus) of naive_mips.
- Arbitrates requests, latches the winning request, and drives it onto a slave port with a request/acknowledge handshake.
- Returns read data to the winning master and stalls each master until its access completes.
- Bounds dbus starvation of ibus and converts a non-responding slave into a bus error after a fixed timeout.

Parameters:
- MAX_D_RUN, 4: maximum consecutive dbus grants while ibus is waiting.
- TIMEOUT, 255: number of BUSY cycles without slv_ack before the access is forcibly completed; 8-bit counter.
- ERR_DATA, 32'hDEADBEEF: read data returned on timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ibus_address  in  32  instruction address
- ibus_byteenable  in  4  byte lanes
- ibus_read  in  1  read request
- ibus_write  in  1  write request
- ibus_wrdata  in  32  write data
- ibus_rddata  out  32  read data, valid in ibus completion cycle
- ibus_stall  out  1  ibus access not yet complete
- dbus_address, dbus_byteenable, dbus_read, dbus_write, dbus_wrdata, dbus_rddata, dbus_stall: same as ibus_*, for the data bus
- slv_address  out  32  latched address
- slv_byteenable  out  4  latched byte lanes
- slv_read  out  1  read strobe, held until ack
- slv_write  out  1  write strobe, held until ack
- slv_wrdata  out  32  latched write data
- slv_rddata  in  32  slave read data, valid with slv_ack
- slv_ack  in  1  slave completion, 1-cycle pulse
- bus_error  out  1  1-cycle pulse on timeout completion

Behaviour:
- Request definition: a master requests when read|write = 1. If both are set, the access is a write. The master holds all of its signals stable until stall = 0.
- States:
  - IDLE: arbitrate. If any request is present, latch the winner's address/byteenable/wrdata/op and go to BUSY_I or BUSY_D at the next edge. No request: stay in IDLE.
  - BUSY_I / BUSY_D: slv_* driven from latched registers. On slv_ack or timeout, go to IDLE at the next edge.
- Arbitration:
  - dbus has priority.
  - d_run counter (3+ bits) increments on each dbus grant made while ibus is requesting. It clears on any ibus grant, and clears on a dbus grant when ibus is not requesting.
  - When d_run == MAX_D_RUN and ibus is requesting, ibus wins.
- Latency: minimum 2 cycles per access. Request seen in IDLE in cycle 0; slave strobes high in cycle 1; slv_ack in cycle 1 completes the access in cycle 1.
- Stall, combinational: <m>_stall = <m>_request & ~(state == BUSY_<m> & (slv_ack | timeout_hit)).
  - A master losing arbitration stays stalled.
  - The completion cycle has stall = 0 and valid rddata.
- Read data:
  - <m>_rddata = slv_rddata when its completion is by ack.
  - <m>_rddata = ERR_DATA on timeout.
  - <m>_rddata = 0 otherwise.
- Timeout:
  - tcnt clears on entry to BUSY and increments each BUSY cycle without ack.
  - timeout_hit = (tcnt == TIMEOUT) & ~slv_ack.
  - On timeout_hit: completion with bus_error = 1 for that cycle; strobes drop next edge.
- slv_read/slv_write are 0 in IDLE. Latched registers only update on a grant; no update in BUSY even if the master changes its inputs (protocol violation tolerated).
- slv_ack in IDLE is ignored.
- Back-to-back accesses: after completion there is always one IDLE cycle, so a held or new request is granted at the earliest one cycle after completion.
- Reset (synchronous, also mid-transaction), at the reset edge:
  - state = IDLE, d_run = 0, tcnt = 0.
  - Latched slv_address/byteenable/wrdata = 0.
  - slv_read = slv_write = 0, bus_error = 0.
  - While rst = 1, both stalls are forced to 0 and rddata outputs to 0.
  - An outstanding slave access is abandoned; a late slv_ack is ignored.

Test Plan:
- Single ibus read, addr 0x80000000, slave acks after 2 BUSY cycles with 0x3C011234 -> slv_read high 2 cycles; ibus_stall = 1 in cycles 0–1 and 0 in cycle 2; ibus_rddata = 0x3C011234 in cycle 2.
- Simultaneous ibus read 0x80000004 and dbus write 0x00000010/0xAABBCCDD/be = 4'b0011, immediate ack -> dbus served first with slv_write = 1, slv_byteenable = 0011 and dbus_stall falling first; ibus granted 1 cycle after dbus completion.
- dbus requests continuously with ibus held pending, MAX_D_RUN = 4, immediate ack -> grant order D,D,D,D,I,D,D,D,D,I; ibus_stall drops exactly once per 5 grants.
- Slave never acks, TIMEOUT = 255 -> dbus read completes in the 256th BUSY cycle; dbus_rddata = 0xDEADBEEF; bus_error pulses once; state returns to IDLE.
- rst asserted in the 3rd BUSY cycle of an ibus read, then slv_ack pulsed 1 cycle after rst deasserts -> slv_read = 0 after the reset edge; no completion and no bus_error; a fresh request arbitrates normally.
- dbus read and write both set, addr 0x20 -> treated as a write: slv_write = 1, slv_read = 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares one slave port between ibus and dbus. dbus has priority, with a bounded run while ibus waits.
// Each access takes at least 2 cycles; a master stays stalled until slv_ack or the timeout completes it.
module mem_bus_arbiter #(
    parameter int unsigned MAX_D_RUN = 4,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ibus_address,
    input  logic [3:0]  ibus_byteenable,
    input  logic        ibus_read,
    input  logic        ibus_write,
    input  logic [31:0] ibus_wrdata,
    output logic [31:0] ibus_rddata,
    output logic        ibus_stall,
    input  logic [31:0] dbus_address,
    input  logic [3:0]  dbus_byteenable,
    input  logic        dbus_read,
    input  logic        dbus_write,
    input  logic [31:0] dbus_wrdata,
    output logic [31:0] dbus_rddata,
    output logic        dbus_stall,
    output logic [31:0] slv_address,
    output logic [3:0]  slv_byteenable,
    output logic        slv_read,
    output logic        slv_write,
    output logic [31:0] slv_wrdata,
    input  logic [31:0] slv_rddata,
    input  logic        slv_ack,
    output logic        bus_error
);
    localparam int unsigned RW = ($clog2(MAX_D_RUN + 1) < 3) ? 3 : $clog2(MAX_D_RUN + 1);
    localparam logic [RW-1:0] MAX_RUN = RW'(MAX_D_RUN);
    localparam logic [7:0]    TMO     = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] d_run, d_run_nxt;
    logic [7:0]    tcnt, tcnt_nxt;
    logic [31:0]   lat_address, lat_wrdata;
    logic [3:0]    lat_byteenable;
    logic          lat_write;
    logic          ireq, dreq, grant_i, grant_d, busy, timeout_hit, done;

    assign ireq = ibus_read | ibus_write;
    assign dreq = dbus_read | dbus_write;
    assign busy = (state != IDLE);

    // ibus only overrides dbus once dbus has used up its run while ibus was waiting
    assign grant_d = (state == IDLE) & dreq & ~(ireq & (d_run == MAX_RUN));
    assign grant_i = (state == IDLE) & ireq & ~grant_d;

    assign timeout_hit = busy & (tcnt == TMO) & ~slv_ack;
    assign done        = busy & (slv_ack | timeout_hit);

    always_comb begin
        state_nxt = state;
        d_run_nxt = d_run;
        tcnt_nxt  = tcnt;
        case (state)
            IDLE: begin
                tcnt_nxt = 8'd0;
                if (grant_d) begin
                    state_nxt = BUSY_D;
                    d_run_nxt = ireq ? d_run + 1'b1 : '0;
                end else if (grant_i) begin
                    state_nxt = BUSY_I;
                    d_run_nxt = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (done)
                    state_nxt = IDLE;
                else
                    tcnt_nxt = tcnt + 8'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            d_run          <= '0;
            tcnt           <= 8'd0;
            lat_address    <= 32'd0;
            lat_byteenable <= 4'd0;
            lat_wrdata     <= 32'd0;
            lat_write      <= 1'b0;
        end else begin
            state <= state_nxt;
            d_run <= d_run_nxt;
            tcnt  <= tcnt_nxt;
            if (grant_d) begin
                lat_address    <= dbus_address;
                lat_byteenable <= dbus_byteenable;
                lat_wrdata     <= dbus_wrdata;
                lat_write      <= dbus_write;
            end else if (grant_i) begin
                lat_address    <= ibus_address;
                lat_byteenable <= ibus_byteenable;
                lat_wrdata     <= ibus_wrdata;
                lat_write      <= ibus_write;
            end
        end
    end

    assign slv_address    = lat_address;
    assign slv_byteenable = lat_byteenable;
    assign slv_wrdata     = lat_wrdata;
    assign slv_read       = busy & ~lat_write;
    assign slv_write      = busy & lat_write;

    always_comb begin
        ibus_stall  = 1'b0;
        dbus_stall  = 1'b0;
        ibus_rddata = 32'd0;
        dbus_rddata = 32'd0;
        bus_error   = 1'b0;
        if (!rst) begin
            ibus_stall = ireq & ~((state == BUSY_I) & done);
            dbus_stall = dreq & ~((state == BUSY_D) & done);
            bus_error  = timeout_hit;
            if (state == BUSY_I)
                ibus_rddata = slv_ack ? slv_rddata : (timeout_hit ? ERR_DATA : 32'd0);
            if (state == BUSY_D)
                dbus_rddata = slv_ack ? slv_rddata : (timeout_hit ? ERR_DATA : 32'd0);
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios plus a randomized run checked against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;
    localparam int          MAX_D_RUN = 4;
    localparam int          TIMEOUT   = 255;
    localparam logic [31:0] ERR_DATA  = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ibus_address, ibus_wrdata, ibus_rddata;
    logic [3:0]  ibus_byteenable;
    logic        ibus_read, ibus_write, ibus_stall;
    logic [31:0] dbus_address, dbus_wrdata, dbus_rddata;
    logic [3:0]  dbus_byteenable;
    logic        dbus_read, dbus_write, dbus_stall;
    logic [31:0] slv_address, slv_wrdata, slv_rddata;
    logic [3:0]  slv_byteenable;
    logic        slv_read, slv_write, slv_ack, bus_error;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.MAX_D_RUN(MAX_D_RUN), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
        .clk(clk), .rst(rst),
        .ibus_address(ibus_address), .ibus_byteenable(ibus_byteenable), .ibus_read(ibus_read),
        .ibus_write(ibus_write), .ibus_wrdata(ibus_wrdata), .ibus_rddata(ibus_rddata), .ibus_stall(ibus_stall),
        .dbus_address(dbus_address), .dbus_byteenable(dbus_byteenable), .dbus_read(dbus_read),
        .dbus_write(dbus_write), .dbus_wrdata(dbus_wrdata), .dbus_rddata(dbus_rddata), .dbus_stall(dbus_stall),
        .slv_address(slv_address), .slv_byteenable(slv_byteenable), .slv_read(slv_read),
        .slv_write(slv_write), .slv_wrdata(slv_wrdata), .slv_rddata(slv_rddata), .slv_ack(slv_ack),
        .bus_error(bus_error)
    );

    task automatic clear_inputs();
        ibus_address = 0; ibus_byteenable = 0; ibus_read = 0; ibus_write = 0; ibus_wrdata = 0;
        dbus_address = 0; dbus_byteenable = 0; dbus_read = 0; dbus_write = 0; dbus_wrdata = 0;
        slv_rddata = 0; slv_ack = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; ibus_read = 1; dbus_write = 1;
        @(negedge clk); #1;
        total++;
        if (ibus_stall !== 1'b0 || dbus_stall !== 1'b0) begin
            bad++; $display("FAIL reset_stall: got i=%b d=%b exp 0 0", ibus_stall, dbus_stall);
        end
        total++;
        if ({slv_read, slv_write, bus_error} !== 3'b000) begin
            bad++; $display("FAIL reset_strobes: got rd/wr/err=%b exp 000", {slv_read, slv_write, bus_error});
        end
        total++;
        if ({slv_address, slv_byteenable, slv_wrdata, ibus_rddata, dbus_rddata} !== 132'd0) begin
            bad++; $display("FAIL reset_regs: got addr=%h be=%h wd=%h ird=%h drd=%h exp all 0",
                            slv_address, slv_byteenable, slv_wrdata, ibus_rddata, dbus_rddata);
        end
        @(negedge clk);
        clear_inputs(); rst = 0;
    endtask

    task automatic test_single_read();
        int rd_high = 0;
        @(negedge clk);
        ibus_read = 1; ibus_address = 32'h80000000; ibus_byteenable = 4'hF;
        #1;
        if (slv_read) rd_high++;
        total++;
        if (ibus_stall !== 1'b1) begin bad++; $display("FAIL single_c0_stall: got %b exp 1", ibus_stall); end
        @(negedge clk); #1;
        if (slv_read) rd_high++;
        total++;
        if (ibus_stall !== 1'b1 || slv_address !== 32'h80000000) begin
            bad++; $display("FAIL single_c1: got stall=%b addr=%h exp 1 80000000", ibus_stall, slv_address);
        end
        @(negedge clk);
        slv_ack = 1; slv_rddata = 32'h3C011234;
        #1;
        if (slv_read) rd_high++;
        total++;
        if (ibus_stall !== 1'b0 || ibus_rddata !== 32'h3C011234) begin
            bad++; $display("FAIL single_c2: got stall=%b rd=%h exp 0 3c011234", ibus_stall, ibus_rddata);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        if (slv_read) rd_high++;
        total++;
        if (rd_high != 2) begin bad++; $display("FAIL single_rd_cycles: got %0d exp 2", rd_high); end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        ibus_read = 1; ibus_address = 32'h80000004; ibus_byteenable = 4'hF;
        dbus_write = 1; dbus_address = 32'h10; dbus_wrdata = 32'hAABBCCDD; dbus_byteenable = 4'b0011;
        #1;
        total++;
        if ({ibus_stall, dbus_stall} !== 2'b11) begin
            bad++; $display("FAIL simul_c0_stall: got %b exp 11", {ibus_stall, dbus_stall});
        end
        @(negedge clk);
        slv_ack = 1; slv_rddata = 32'h0;
        #1;
        total++;
        if ({slv_write, slv_read, slv_byteenable, slv_address, slv_wrdata, dbus_stall, ibus_stall}
            !== {1'b1, 1'b0, 4'b0011, 32'h10, 32'hAABBCCDD, 1'b0, 1'b1}) begin
            bad++; $display("FAIL simul_dbus: got wr=%b rd=%b be=%b addr=%h wd=%h ds=%b is=%b", slv_write,
                            slv_read, slv_byteenable, slv_address, slv_wrdata, dbus_stall, ibus_stall);
        end
        @(negedge clk);
        slv_ack = 0; dbus_write = 0;
        #1;
        total++;
        if ({slv_read, slv_write, ibus_stall} !== 3'b001) begin
            bad++; $display("FAIL simul_gap: got rd/wr/is=%b exp 001", {slv_read, slv_write, ibus_stall});
        end
        @(negedge clk);
        slv_ack = 1; slv_rddata = 32'h11112222;
        #1;
        total++;
        if ({slv_read, slv_address, ibus_stall, ibus_rddata, dbus_rddata}
            !== {1'b1, 32'h80000004, 1'b0, 32'h11112222, 32'h0}) begin
            bad++; $display("FAIL simul_ibus: got rd=%b addr=%h is=%b ird=%h drd=%h", slv_read, slv_address,
                            ibus_stall, ibus_rddata, dbus_rddata);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_starvation();
        int grants = 0;
        int drops = 0;
        int cyc = 0;
        ibus_read = 1; ibus_address = 32'h100;
        dbus_read = 1; dbus_address = 32'h200;
        while (grants < 10 && cyc < 60) begin
            @(negedge clk);
            slv_ack = slv_read | slv_write;
            #1;
            cyc++;
            if (!ibus_stall) drops++;
            if (slv_read) begin
                total++;
                if (slv_address !== ((grants % 5 == 4) ? 32'h100 : 32'h200)) begin
                    bad++; $display("FAIL starve_grant%0d: got addr=%h exp %h", grants, slv_address,
                                    (grants % 5 == 4) ? 32'h100 : 32'h200);
                end
                grants++;
            end
        end
        total++;
        if (grants != 10) begin bad++; $display("FAIL starve_budget: got %0d grants exp 10", grants); end
        total++;
        if (drops != 2) begin bad++; $display("FAIL starve_idrops: got %0d exp 2", drops); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_timeout();
        int busy = 0;
        int errs = 0;
        int cyc = 0;
        bit seen = 0;
        @(negedge clk);
        dbus_read = 1; dbus_address = 32'h44;
        while (!seen && cyc < 300) begin
            #1;
            if (slv_read) busy++;
            if (bus_error) errs++;
            if (!dbus_stall) begin
                seen = 1;
                total++;
                if (busy != 256 || dbus_rddata !== ERR_DATA || bus_error !== 1'b1) begin
                    bad++; $display("FAIL timeout_done: got busy=%0d rd=%h err=%b exp 256 deadbeef 1",
                                    busy, dbus_rddata, bus_error);
                end
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL timeout_budget: got no completion exp completion"); end
        @(negedge clk);
        dbus_read = 0;
        #1;
        if (bus_error) errs++;
        total++;
        if (slv_read !== 1'b0 || errs != 1) begin
            bad++; $display("FAIL timeout_after: got rd=%b errs=%0d exp 0 1", slv_read, errs);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ibus_read = 1; ibus_address = 32'h80000010;
        repeat (3) @(negedge clk);
        rst = 1;
        #1;
        total++;
        if ({ibus_stall, dbus_stall, ibus_rddata} !== 34'd0) begin
            bad++; $display("FAIL rstmid_forced: got is=%b ds=%b ird=%h exp 0", ibus_stall, dbus_stall, ibus_rddata);
        end
        @(negedge clk);
        rst = 0; ibus_read = 0;
        #1;
        total++;
        if (slv_read !== 1'b0) begin bad++; $display("FAIL rstmid_strobe: got %b exp 0", slv_read); end
        @(negedge clk);
        slv_ack = 1; slv_rddata = 32'h12345678;
        #1;
        total++;
        if ({bus_error, slv_read, ibus_rddata} !== 34'd0) begin
            bad++; $display("FAIL rstmid_lateack: got err=%b rd=%b ird=%h exp 0", bus_error, slv_read, ibus_rddata);
        end
        @(negedge clk);
        slv_ack = 0; dbus_read = 1; dbus_address = 32'h30;
        #1;
        total++;
        if ({dbus_stall, slv_read} !== 2'b10) begin
            bad++; $display("FAIL rstmid_fresh_c0: got %b exp 10", {dbus_stall, slv_read});
        end
        @(negedge clk);
        slv_ack = 1; slv_rddata = 32'hCAFEF00D;
        #1;
        total++;
        if ({slv_read, slv_address, dbus_stall, dbus_rddata} !== {1'b1, 32'h30, 1'b0, 32'hCAFEF00D}) begin
            bad++; $display("FAIL rstmid_fresh_c1: got rd=%b addr=%h ds=%b drd=%h", slv_read, slv_address,
                            dbus_stall, dbus_rddata);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_read_write_both();
        @(negedge clk);
        dbus_read = 1; dbus_write = 1; dbus_address = 32'h20; dbus_wrdata = 32'h55;
        @(negedge clk);
        slv_ack = 1;
        #1;
        total++;
        if ({slv_write, slv_read, slv_address, dbus_stall} !== {1'b1, 1'b0, 32'h20, 1'b0}) begin
            bad++; $display("FAIL both_set: got wr=%b rd=%b addr=%h ds=%b exp 1 0 20 0",
                            slv_write, slv_read, slv_address, dbus_stall);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    // Model: at most one access outstanding; owner 0=none 1=ibus 2=dbus.
    task automatic test_random();
        int owner = 0, drun = 0, waited = 0;
        logic [31:0] m_addr = 0, m_wd = 0;
        logic [3:0]  m_be = 0;
        bit m_wr = 0, i_free = 1, d_free = 1;
        bit ireq, dreq, hit, ci, cd;
        logic [31:0] e_ird, e_drd;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        repeat (2000) begin
            @(negedge clk);
            if (i_free) begin
                ibus_read = 0; ibus_write = 0;
                if ($urandom_range(0, 1) == 1) begin
                    {ibus_write, ibus_read} = 2'($urandom_range(1, 3));
                    ibus_address = $urandom; ibus_wrdata = $urandom; ibus_byteenable = 4'($urandom);
                end
            end
            if (d_free) begin
                dbus_read = 0; dbus_write = 0;
                if ($urandom_range(0, 2) != 0) begin
                    {dbus_write, dbus_read} = 2'($urandom_range(1, 3));
                    dbus_address = $urandom; dbus_wrdata = $urandom; dbus_byteenable = 4'($urandom);
                end
            end
            slv_ack = ($urandom_range(0, 2) == 0); slv_rddata = $urandom;
            #1;
            ireq = ibus_read | ibus_write;
            dreq = dbus_read | dbus_write;
            hit = (owner != 0) && (waited == TIMEOUT) && !slv_ack;
            ci = (owner == 1) && (slv_ack || hit);
            cd = (owner == 2) && (slv_ack || hit);
            e_ird = ci ? (slv_ack ? slv_rddata : ERR_DATA) : 32'd0;
            e_drd = cd ? (slv_ack ? slv_rddata : ERR_DATA) : 32'd0;
            total++;
            if ({ibus_stall, dbus_stall, bus_error} !== {ireq && !ci, dreq && !cd, hit}) begin
                bad++; $display("FAIL rand_stall: got is/ds/err=%b exp %b", {ibus_stall, dbus_stall, bus_error},
                                {ireq && !ci, dreq && !cd, hit});
            end
            total++;
            if ({ibus_rddata, dbus_rddata} !== {e_ird, e_drd}) begin
                bad++; $display("FAIL rand_rddata: got i=%h d=%h exp i=%h d=%h", ibus_rddata, dbus_rddata, e_ird, e_drd);
            end
            total++;
            if ({slv_read, slv_write, slv_address, slv_byteenable, slv_wrdata}
                !== {owner != 0 && !m_wr, owner != 0 && m_wr, m_addr, m_be, m_wd}) begin
                bad++; $display("FAIL rand_slave: got rd=%b wr=%b a=%h be=%h wd=%h exp rd=%b wr=%b a=%h be=%h wd=%h",
                                slv_read, slv_write, slv_address, slv_byteenable, slv_wrdata,
                                owner != 0 && !m_wr, owner != 0 && m_wr, m_addr, m_be, m_wd);
            end
            i_free = !ireq || ci;
            d_free = !dreq || cd;
            @(posedge clk);
            if (owner == 0) begin
                waited = 0;
                if (dreq && !(ireq && drun == MAX_D_RUN)) begin
                    owner = 2; drun = ireq ? drun + 1 : 0;
                    m_addr = dbus_address; m_be = dbus_byteenable; m_wd = dbus_wrdata; m_wr = dbus_write;
                end else if (ireq) begin
                    owner = 1; drun = 0;
                    m_addr = ibus_address; m_be = ibus_byteenable; m_wd = ibus_wrdata; m_wr = ibus_write;
                end
            end else if (ci || cd) begin
                owner = 0;
            end else begin
                waited++;
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_reset_mid();
        test_read_write_both();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
